i2c_frame_decoder: RTL and testbench

// - Downstream of the I2C START/STOP detector. Clocked by bus SCL; consumes start_pulse/stop_pulse plus raw SDA.
// - Deserialises each I2C frame: 7-bit address, R/W bit, address ACK, then data bytes each followed by an ACK bit.
// - Emits one-cycle valid strobes, a byte count and frame status for the analyzer capture/log stage.

---
 rtl/i2c_frame_decoder.sv | 245 ++++++++++++++++++++++++
 tb/tb_i2c_frame_decoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_frame_decoder.sv
// -----------------------------------------------------------------------------
// i2c_frame_decoder
//
// Purpose:
//   Sits behind the I2C START/STOP detector and is clocked by bus SCL. It
//   deserialises each frame (7-bit address + R/W, address ACK, then data bytes
//   each followed by an ACK bit). It publishes one-cycle valid strobes, a
//   saturating per-frame byte count and frame status for the capture/log stage.
//
// Configuration macro:
//   I2C_ADDR_FILTER_EN - when defined, only frames addressed to MATCH_ADDR are
//                        decoded past the address byte. addr_match becomes a
//                        registered flag. When the macro is undefined, every
//                        frame is decoded and addr_match is tied high.
//
// Ports:
//   scl          in   clock, all state changes on posedge
//   resetn       in   asynchronous active-low reset
//   sda          in   raw SDA, sampled on posedge scl
//   start_pulse  in   START / repeated-START strobe (one SCL period)
//   stop_pulse   in   STOP strobe (one SCL period)
//   addr         out  last captured 7-bit address
//   rw           out  last captured R/W bit (1 = read)
//   addr_valid   out  one-cycle strobe: addr/rw updated
//   addr_match   out  address equals MATCH_ADDR (tied 1 without the filter)
//   data         out  last captured data byte
//   data_valid   out  one-cycle strobe: data updated
//   ack          out  last sampled ACK bit (0 = ACK, 1 = NACK)
//   ack_valid    out  one-cycle strobe: ack updated
//   byte_cnt     out  data bytes in the current frame, saturates at MAX_BYTES
//   busy         out  frame in progress
//   frame_done   out  one-cycle strobe on STOP while busy
//   ovf          out  sticky: more than MAX_BYTES bytes seen; cleared by START
// -----------------------------------------------------------------------------
module i2c_frame_decoder #(
  parameter int         MAX_BYTES  = 16,
  parameter int         CNT_W      = 5,
  parameter logic [6:0] MATCH_ADDR = 7'h50
) (
  input  logic             scl,
  input  logic             resetn,
  input  logic             sda,
  input  logic             start_pulse,
  input  logic             stop_pulse,
  output logic [6:0]       addr,
  output logic             rw,
  output logic             addr_valid,
  output logic             addr_match,
  output logic [7:0]       data,
  output logic             data_valid,
  output logic             ack,
  output logic             ack_valid,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             busy,
  output logic             frame_done,
  output logic             ovf
);

`ifdef I2C_ADDR_FILTER_EN
  localparam logic FILTER_EN = 1'b1;
`else
  localparam logic FILTER_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_SKIP
  } state_t;

  state_t state_reg, state_next;

  logic             prev_sda_reg;
  logic [6:0]       shreg_reg, shreg_next;
  logic [3:0]       bitcnt_reg, bitcnt_next;
  logic [6:0]       addr_reg, addr_next;
  logic             rw_reg, rw_next;
  logic             addr_valid_reg, addr_valid_next;
  logic [7:0]       data_reg, data_next;
  logic             data_valid_reg, data_valid_next;
  logic             ack_reg, ack_next;
  logic             ack_valid_reg, ack_valid_next;
  logic [CNT_W-1:0] byte_cnt_reg, byte_cnt_next;
  logic             busy_reg, busy_next;
  logic             frame_done_reg, frame_done_next;
  logic             ovf_reg, ovf_next;

  // A STOP only means something while a frame is open.
  logic stop_hit;
  // shreg holds the seven address bits at the capture edge.
  logic addr_hit;
  // Capture happens on the edge that brings the bit count to 8.
  logic last_bit;

  assign stop_hit = stop_pulse && busy_reg;
  assign addr_hit = !FILTER_EN || (shreg_reg == MATCH_ADDR);
  assign last_bit = (bitcnt_reg == 4'd7);

  // State register
  always_ff @(posedge scl or negedge resetn) begin
    if (!resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic. START wins over everything, so a same-edge START+STOP
  // lands in ADDR with the old frame closed by the STOP strobe.
  always_comb begin
    state_next = state_reg;
    if (start_pulse) begin
      state_next = S_ADDR;
    end else if (stop_hit) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_ADDR:     if (last_bit) state_next = addr_hit ? S_ADDR_ACK : S_SKIP;
        S_DATA:     if (last_bit) state_next = S_DATA_ACK;
        S_ADDR_ACK,
        S_DATA_ACK: state_next = sda ? S_SKIP : S_DATA;
        default:    state_next = state_reg;
      endcase
    end
  end

`ifdef I2C_ADDR_FILTER_EN
  logic addr_match_reg, addr_match_next;
  assign addr_match = addr_match_reg;
`else
  assign addr_match = 1'b1;
`endif

  // Output / datapath logic
  always_comb begin
    shreg_next      = shreg_reg;
    bitcnt_next     = bitcnt_reg;
    addr_next       = addr_reg;
    rw_next         = rw_reg;
    addr_valid_next = 1'b0;
    data_next       = data_reg;
    data_valid_next = 1'b0;
    ack_next        = ack_reg;
    ack_valid_next  = 1'b0;
    byte_cnt_next   = byte_cnt_reg;
    busy_next       = busy_reg;
    frame_done_next = 1'b0;
    ovf_next        = ovf_reg;
`ifdef I2C_ADDR_FILTER_EN
    addr_match_next = addr_match_reg;
`endif

    if (stop_hit) begin
      frame_done_next = 1'b1;
      busy_next       = 1'b0;
    end

    if (start_pulse) begin
      // The detector reports START one edge late: the address MSB is the
      // previous SDA sample, the current sample is bit 6.
      shreg_next    = {5'b0, prev_sda_reg, sda};
      bitcnt_next   = 4'd2;
      busy_next     = 1'b1;
      byte_cnt_next = '0;
      ovf_next      = 1'b0;
    end else if (!stop_hit) begin
      case (state_reg)
        S_ADDR, S_DATA: begin
          shreg_next  = {shreg_reg[5:0], sda};
          bitcnt_next = bitcnt_reg + 4'd1;
          if (last_bit) begin
            if (state_reg == S_ADDR) begin
              addr_next       = shreg_reg;
              rw_next         = sda;
              addr_valid_next = 1'b1;
`ifdef I2C_ADDR_FILTER_EN
              addr_match_next = addr_hit;
`endif
            end else begin
              data_next       = {shreg_reg, sda};
              data_valid_next = 1'b1;
              if (byte_cnt_reg == CNT_W'(MAX_BYTES)) ovf_next = 1'b1;
              else byte_cnt_next = byte_cnt_reg + 1'b1;
            end
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          ack_next       = sda;
          ack_valid_next = 1'b1;
          bitcnt_next    = 4'd0;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge scl or negedge resetn) begin
    if (!resetn) begin
      prev_sda_reg   <= 1'b0;
      shreg_reg      <= '0;
      bitcnt_reg     <= '0;
      addr_reg       <= '0;
      rw_reg         <= 1'b0;
      addr_valid_reg <= 1'b0;
      data_reg       <= '0;
      data_valid_reg <= 1'b0;
      ack_reg        <= 1'b0;
      ack_valid_reg  <= 1'b0;
      byte_cnt_reg   <= '0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      ovf_reg        <= 1'b0;
`ifdef I2C_ADDR_FILTER_EN
      addr_match_reg <= 1'b0;
`endif
    end else begin
      prev_sda_reg   <= sda;
      shreg_reg      <= shreg_next;
      bitcnt_reg     <= bitcnt_next;
      addr_reg       <= addr_next;
      rw_reg         <= rw_next;
      addr_valid_reg <= addr_valid_next;
      data_reg       <= data_next;
      data_valid_reg <= data_valid_next;
      ack_reg        <= ack_next;
      ack_valid_reg  <= ack_valid_next;
      byte_cnt_reg   <= byte_cnt_next;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
      ovf_reg        <= ovf_next;
`ifdef I2C_ADDR_FILTER_EN
      addr_match_reg <= addr_match_next;
`endif
    end
  end

  assign addr       = addr_reg;
  assign rw         = rw_reg;
  assign addr_valid = addr_valid_reg;
  assign data       = data_reg;
  assign data_valid = data_valid_reg;
  assign ack        = ack_reg;
  assign ack_valid  = ack_valid_reg;
  assign byte_cnt   = byte_cnt_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign ovf        = ovf_reg;

endmodule

// File: tb/tb_i2c_frame_decoder.sv
// -----------------------------------------------------------------------------
// tb_i2c_frame_decoder
//
// Drives bit-level I2C frames into i2c_frame_decoder: a table of single-byte
// frames with hand-computed results, followed by hand-written sequences for
// read NACK/skip, repeated START, byte-count saturation, STOP while idle,
// same-edge START+STOP and reset mid-frame. Honours I2C_ADDR_FILTER_EN.
// -----------------------------------------------------------------------------
module tb_i2c_frame_decoder;

`ifdef I2C_ADDR_FILTER_EN
  localparam logic FILT = 1'b1;
`else
  localparam logic FILT = 1'b0;
`endif

  logic       scl = 1'b0;
  logic       resetn;
  logic       sda;
  logic       start_pulse;
  logic       stop_pulse;
  logic [6:0] addr;
  logic       rw;
  logic       addr_valid;
  logic       addr_match;
  logic [7:0] data;
  logic       data_valid;
  logic       ack;
  logic       ack_valid;
  logic [4:0] byte_cnt;
  logic       busy;
  logic       frame_done;
  logic       ovf;

  i2c_frame_decoder dut (
    .scl(scl), .resetn(resetn), .sda(sda),
    .start_pulse(start_pulse), .stop_pulse(stop_pulse),
    .addr(addr), .rw(rw), .addr_valid(addr_valid), .addr_match(addr_match),
    .data(data), .data_valid(data_valid), .ack(ack), .ack_valid(ack_valid),
    .byte_cnt(byte_cnt), .busy(busy), .frame_done(frame_done), .ovf(ovf)
  );

  always #5 scl = ~scl;

  int n_checks = 0;
  int n_fail   = 0;

  // Strobe counters, sampled mid-cycle.
  int cnt_av = 0, cnt_dv = 0, cnt_akv = 0, cnt_fd = 0;
  bit overlap_seen = 1'b0;

  always @(negedge scl) begin
    if (addr_valid) cnt_av  <= cnt_av + 1;
    if (data_valid) cnt_dv  <= cnt_dv + 1;
    if (ack_valid)  cnt_akv <= cnt_akv + 1;
    if (frame_done) cnt_fd  <= cnt_fd + 1;
    if (int'(addr_valid) + int'(data_valid) + int'(ack_valid) + int'(frame_done) > 1)
      overlap_seen <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Entered just after a falling edge; drives one bit, lets one rising edge
  // pass, and returns just after the following falling edge.
  task automatic bit_edge(input logic b, input logic st, input logic sp);
    sda = b; start_pulse = st; stop_pulse = sp;
    @(posedge scl);
    @(negedge scl);
    #1;
  endtask

  task automatic send_addr(input logic [7:0] b);
    bit_edge(b[7], 1'b0, 1'b0);
    bit_edge(b[6], 1'b1, 1'b0);
    for (int i = 5; i >= 0; i--) bit_edge(b[i], 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bit_edge(b[i], 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [7:0] abyte;
    logic       ack0;
    logic [7:0] dbyte;
    logic       ack1;
    logic [6:0] e_addr;
    logic       e_rw;
    logic [7:0] e_data;
    logic       e_ack;
    logic       e_match;
    int         e_dv;
    int         e_akv;
    logic [4:0] e_bc;
  } vec_t;

  vec_t vecs [6];

  int s_av, s_dv, s_akv, s_fd;

  task automatic snap();
    s_av = cnt_av; s_dv = cnt_dv; s_akv = cnt_akv; s_fd = cnt_fd;
  endtask

  initial begin
    //              abyte  a0    dbyte  a1    addr   rw    data   ack   match dv akv bc
    vecs[0] = '{8'hA0, 1'b0, 8'h3C, 1'b0, 7'h50, 1'b0, 8'h3C, 1'b0, 1'b1, 1, 2, 5'd1};
    vecs[1] = '{8'hA1, 1'b0, 8'hFF, 1'b1, 7'h50, 1'b1, 8'hFF, 1'b1, 1'b1, 1, 2, 5'd1};
    vecs[2] = '{8'hA0, 1'b0, 8'h81, 1'b1, 7'h50, 1'b0, 8'h81, 1'b1, 1'b1, 1, 2, 5'd1};
    vecs[3] = '{8'hA1, 1'b0, 8'h00, 1'b0, 7'h50, 1'b1, 8'h00, 1'b0, 1'b1, 1, 2, 5'd1};
    // Address NACKed: data byte is skipped, data keeps the previous value.
    vecs[4] = '{8'hA0, 1'b1, 8'h5A, 1'b0, 7'h50, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1, 5'd0};
`ifdef I2C_ADDR_FILTER_EN
    // 0x2A does not match: nothing after the address strobe.
    vecs[5] = '{8'h55, 1'b0, 8'hC3, 1'b0, 7'h2A, 1'b1, 8'h00, 1'b1, 1'b0, 0, 0, 5'd0};
`else
    vecs[5] = '{8'h55, 1'b0, 8'hC3, 1'b0, 7'h2A, 1'b1, 8'hC3, 1'b0, 1'b1, 1, 2, 5'd1};
`endif

    resetn = 1'b0; sda = 1'b1; start_pulse = 1'b0; stop_pulse = 1'b0;
    @(negedge scl); #1;
    bit_edge(1'b1, 1'b0, 1'b0);
    bit_edge(1'b1, 1'b0, 1'b0);
    chk("rst_addr", addr, 7'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_byte_cnt", byte_cnt, 5'd0);
    chk("rst_addr_match", addr_match, !FILT);
    resetn = 1'b1;
    bit_edge(1'b1, 1'b0, 1'b0);

    // ---------------- table of single-byte frames ----------------
    for (int i = 0; i < 6; i++) begin
      snap();
      send_addr(vecs[i].abyte);
      chk($sformatf("v%0d_addr_valid", i), addr_valid, 1'b1);
      bit_edge(vecs[i].ack0, 1'b0, 1'b0);
      send_byte(vecs[i].dbyte);
      bit_edge(vecs[i].ack1, 1'b0, 1'b0);
      bit_edge(1'b1, 1'b0, 1'b1);
      chk($sformatf("v%0d_frame_done", i), frame_done, 1'b1);
      bit_edge(1'b1, 1'b0, 1'b0);
      bit_edge(1'b1, 1'b0, 1'b0);
      chk($sformatf("v%0d_addr", i), addr, vecs[i].e_addr);
      chk($sformatf("v%0d_rw", i), rw, vecs[i].e_rw);
      chk($sformatf("v%0d_data", i), data, vecs[i].e_data);
      chk($sformatf("v%0d_ack", i), ack, vecs[i].e_ack);
      chk($sformatf("v%0d_addr_match", i), addr_match, vecs[i].e_match);
      chk($sformatf("v%0d_byte_cnt", i), byte_cnt, vecs[i].e_bc);
      chk($sformatf("v%0d_busy", i), busy, 1'b0);
      chk($sformatf("v%0d_n_addr_valid", i), cnt_av - s_av, 1);
      chk($sformatf("v%0d_n_data_valid", i), cnt_dv - s_dv, vecs[i].e_dv);
      chk($sformatf("v%0d_n_ack_valid", i), cnt_akv - s_akv, vecs[i].e_akv);
      chk($sformatf("v%0d_n_frame_done", i), cnt_fd - s_fd, 1);
    end

    // ---------------- read, data NACK, skipped bits ----------------
    snap();
    send_addr(8'hA1);
    bit_edge(1'b0, 1'b0, 1'b0);
    send_byte(8'hFF);
    bit_edge(1'b1, 1'b0, 1'b0);
    chk("rd_ack_valid", ack_valid, 1'b1);
    chk("rd_ack", ack, 1'b1);
    send_byte(8'h00);
    chk("rd_skip_n_data_valid", cnt_dv - s_dv, 1);
    chk("rd_skip_n_ack_valid", cnt_akv - s_akv, 2);
    chk("rd_data", data, 8'hFF);
    chk("rd_rw", rw, 1'b1);
    chk("rd_busy", busy, 1'b1);
    bit_edge(1'b1, 1'b0, 1'b1);
    chk("rd_frame_done", frame_done, 1'b1);

    // ---------------- repeated START ----------------
    snap();
    send_addr(8'hA0);
    bit_edge(1'b0, 1'b0, 1'b0);
    send_byte(8'h12);
    bit_edge(1'b0, 1'b0, 1'b0);
    chk("rs_data", data, 8'h12);
    chk("rs_byte_cnt_1", byte_cnt, 5'd1);
    send_addr(8'hA1);
    chk("rs_addr_valid", addr_valid, 1'b1);
    chk("rs_rw", rw, 1'b1);
    chk("rs_byte_cnt_0", byte_cnt, 5'd0);
    chk("rs_busy", busy, 1'b1);
    chk("rs_n_addr_valid", cnt_av - s_av, 2);
    chk("rs_n_frame_done", cnt_fd - s_fd, 0);
    bit_edge(1'b0, 1'b0, 1'b0);
    bit_edge(1'b1, 1'b0, 1'b1);

    // ---------------- 17 bytes, saturation and overflow ----------------
    snap();
    send_addr(8'hA0);
    bit_edge(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      send_byte(8'(k));
      bit_edge(1'b0, 1'b0, 1'b0);
      if (k == 16) begin
        chk("ovf_cnt_at_16", byte_cnt, 5'd16);
        chk("ovf_flag_at_16", ovf, 1'b0);
      end
    end
    chk("ovf_cnt_at_17", byte_cnt, 5'd16);
    chk("ovf_flag_at_17", ovf, 1'b1);
    chk("ovf_data_17", data, 8'h11);
    chk("ovf_n_data_valid", cnt_dv - s_dv, 17);
    bit_edge(1'b1, 1'b0, 1'b1);
    chk("ovf_sticky_after_stop", ovf, 1'b1);
    send_addr(8'hA0);
    chk("ovf_cleared_by_start", ovf, 1'b0);
    chk("ovf_cnt_cleared", byte_cnt, 5'd0);
    bit_edge(1'b0, 1'b0, 1'b0);
    bit_edge(1'b1, 1'b0, 1'b1);

    // ---------------- STOP while idle ----------------
    snap();
    bit_edge(1'b1, 1'b0, 1'b1);
    bit_edge(1'b1, 1'b0, 1'b0);
    chk("idle_stop_n_frame_done", cnt_fd - s_fd, 0);

    // ---------------- START and STOP on the same edge ----------------
    send_addr(8'hA0);
    bit_edge(1'b0, 1'b0, 1'b0);
    bit_edge(1'b1, 1'b0, 1'b0);
    bit_edge(1'b0, 1'b0, 1'b0);
    snap();
    bit_edge(1'b1, 1'b0, 1'b0);   // MSB of 0xA0
    bit_edge(1'b0, 1'b1, 1'b1);   // bit 6 with START+STOP
    chk("ss_frame_done", frame_done, 1'b1);
    chk("ss_busy", busy, 1'b1);
    for (int i = 5; i >= 0; i--) bit_edge(i == 5, 1'b0, 1'b0);
    chk("ss_addr_valid", addr_valid, 1'b1);
    chk("ss_addr", addr, 7'h50);
    chk("ss_busy_after_addr", busy, 1'b1);
    bit_edge(1'b1, 1'b0, 1'b1);

    // ---------------- reset after 4 address bits ----------------
    bit_edge(1'b1, 1'b0, 1'b0);
    bit_edge(1'b0, 1'b1, 1'b0);
    bit_edge(1'b1, 1'b0, 1'b0);
    bit_edge(1'b0, 1'b0, 1'b0);
    chk("mr_busy_before", busy, 1'b1);
    resetn = 1'b0;
    #1;
    chk("mr_busy", busy, 1'b0);
    chk("mr_addr", addr, 7'h00);
    chk("mr_data", data, 8'h00);
    chk("mr_ack", ack, 1'b0);
    chk("mr_byte_cnt", byte_cnt, 5'd0);
    chk("mr_addr_match", addr_match, !FILT);
    bit_edge(1'b1, 1'b0, 1'b0);
    resetn = 1'b1;
    snap();
    for (int i = 0; i < 12; i++) bit_edge(i[0], 1'b0, 1'b0);
    chk("mr_n_addr_valid", cnt_av - s_av, 0);
    chk("mr_n_data_valid", cnt_dv - s_dv, 0);
    chk("mr_n_ack_valid", cnt_akv - s_akv, 0);
    chk("mr_busy_after", busy, 1'b0);

    chk("strobes_no_overlap", overlap_seen, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
